fpu_arbiter: RTL and testbench

//  Shares the single combinational half-precision FPU adder (16-bit: 1 sign, 5 exp, 10 mant) between NREQ requesters.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fpu_arbiter_rr_arbiter.sv | 23 ++
 rtl/fpu_arbiter.sv | 105 ++++++++++
 tb/tb_fpu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP16 adder arbiter: format widths, FSM encoding
// and the round-robin pick helper used by rr_arbiter.
package fpu_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int FP_W    = 1 + EXP_W + MAN_W;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // One-hot grant: first valid requester at or above ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && !found && valid[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Combinational round-robin grant for up to eight requesters, returned both
// one-hot and as an index.
module rr_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx
);

    always_comb begin
        grant     = NREQ'(rr_pick(MAX_REQ'(req_valid), 3'(ptr), NREQ));
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = PW'(i);
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Time-shares one external combinational FP16 adder between NREQ requesters:
// round-robin accept, registered operands, SETTLE-cycle wait, held response.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int W      = FP_W,
    parameter int NREQ   = 2,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   res_valid,
    input  logic [NREQ-1:0]   res_ready,
    output logic [W-1:0]      res_data,
    output logic [W-1:0]      fpu_a,
    output logic [W-1:0]      fpu_b,
    input  logic [W-1:0]      fpu_r,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req_valid(req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    assign busy = (state != IDLE);

    always_comb begin
        next_state = state;
        req_ready  = '0;
        res_valid  = '0;
        unique case (state)
            IDLE: begin
                req_ready = grant;
                if (|(req_valid & grant)) next_state = ISSUE;
            end
            ISSUE: begin
                if (cnt == '0) next_state = RESP;
            end
            RESP: begin
                res_valid[gnt] = 1'b1;
                if (res_ready[gnt]) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand, result and bookkeeping registers; reset drops any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fpu_a    <= '0;
            fpu_b    <= '0;
            res_data <= '0;
            gnt      <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            op_count <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                IDLE: begin
                    if (|(req_valid & grant)) begin
                        fpu_a <= req_a[grant_idx*W +: W];
                        fpu_b <= req_b[grant_idx*W +: W];
                        gnt   <= grant_idx;
                        cnt   <= CW'(SETTLE - 1);
                    end
                end
                ISSUE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           res_data <= fpu_r;
                end
                RESP: begin
                    if (res_ready[gnt]) begin
                        op_count <= op_count + 16'd1;
                        rr_ptr   <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized self-checking bench for fpu_arbiter with a behavioural FP16 adder
// standing in for the external FPU and a queue-free round-robin reference model.
module tb_fpu_arbiter;

    localparam int NREQ   = 2;
    localparam int SETTLE = 2;
    localparam int W      = 16;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   res_valid;
    logic [NREQ-1:0]   res_ready;
    logic [W-1:0]      res_data;
    logic [W-1:0]      fpu_a;
    logic [W-1:0]      fpu_b;
    logic [W-1:0]      fpu_r;
    logic              busy;
    logic [15:0]       op_count;

    int          n_checks;
    int          n_fail;
    int          ptr_m;
    logic [15:0] count_m;
    int          last_w;
    bit          pending [NREQ];
    logic [15:0] opa [NREQ];
    logic [15:0] opb [NREQ];
    int          order [4];

    fpu_arbiter #(
        .W(W), .NREQ(NREQ), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_r(fpu_r),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real half_to_real(input logic [15:0] h);
        int  e;
        int  m;
        real mag;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 0) mag = real'(m) * pow2(-24);
        else        mag = real'(1024 + m) * pow2(e - 25);
        return h[15] ? -mag : mag;
    endfunction

    // Round-to-nearest-even conversion; exact sums of two halves fit in a real.
    function automatic logic [15:0] real_to_half(input real v);
        logic s;
        real  a;
        real  x;
        real  fl;
        int   e;
        int   m;
        s = (v < 0.0);
        a = s ? -v : v;
        if (a == 0.0) return {s, 15'd0};
        e = 0;
        while (a >= pow2(e + 1)) e++;
        while (a < pow2(e)) e--;
        if (e < -14) begin
            x = a / pow2(-24);
            e = -15;
        end else begin
            x = (a / pow2(e) - 1.0) * 1024.0;
        end
        fl = $floor(x);
        m  = $rtoi(fl);
        if ((x - fl > 0.5) || ((x - fl == 0.5) && (m % 2 == 1))) m++;
        if (e == -15) return {s, 15'(m)};
        if (m == 1024) begin
            m = 0;
            e++;
        end
        if (e > 15) return {s, 5'h1F, 10'd0};
        return {s, 5'(e + 15), 10'(m)};
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        return real_to_half(half_to_real(a) + half_to_real(b));
    endfunction

    function automatic logic [15:0] rand_half();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 28)), 10'($urandom_range(0, 1023))};
    endfunction

    assign fpu_r = fp16_add(fpu_a, fpu_b);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = pending[i];
            req_a[i*W +: W]      = opa[i];
            req_b[i*W +: W]      = opb[i];
        end
    endtask

    task automatic newRequests();
        bit any;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pending[i] && $urandom_range(0, 1) == 1) begin
                pending[i] = 1'b1;
                opa[i]     = rand_half();
                opb[i]     = rand_half();
            end
            if (pending[i]) any = 1'b1;
        end
        if (!any) begin
            int j;
            j          = $urandom_range(0, NREQ - 1);
            pending[j] = 1'b1;
            opa[j]     = rand_half();
            opb[j]     = rand_half();
        end
    endtask

    // One full transaction: predicted accept, latency, hold under backpressure, completion.
    task automatic runOp(input int hold);
        int          w;
        int          n;
        logic [15:0] exp_r;
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (ptr_m + i) % NREQ;
            if (w < 0 && pending[j]) w = j;
        end
        if (w < 0) w = 0;
        applyStimulus();
        #1;
        checkOutput("req_ready_idle", 32'(req_ready), 32'(1) << w);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        pending[w] = 1'b0;
        applyStimulus();
        exp_r = fp16_add(opa[w], opb[w]);
        checkOutput("fpu_a", 32'(fpu_a), 32'(opa[w]));
        checkOutput("fpu_b", 32'(fpu_b), 32'(opb[w]));
        checkOutput("busy_issue", 32'(busy), 32'd1);
        n = 0;
        while (res_valid == '0 && n < SETTLE + 4) begin
            checkOutput("req_ready_issue", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("latency", 32'(n), 32'(SETTLE));
        checkOutput("res_valid", 32'(res_valid), 32'(1) << w);
        checkOutput("res_data", 32'(res_data), 32'(exp_r));
        for (int k = 0; k < hold; k++) begin
            res_ready = NREQ'($urandom) & ~(NREQ'(1) << w);
            @(posedge clk);
            #1;
            checkOutput("res_valid_hold", 32'(res_valid), 32'(1) << w);
            checkOutput("res_data_hold", 32'(res_data), 32'(exp_r));
            checkOutput("req_ready_resp", 32'(req_ready), 32'd0);
        end
        res_ready = NREQ'(1) << w;
        @(posedge clk);
        #1;
        res_ready = '0;
        count_m   = count_m + 16'd1;
        ptr_m     = (w + 1) % NREQ;
        last_w    = w;
        checkOutput("res_valid_done", 32'(res_valid), 32'd0);
        checkOutput("op_count", 32'(op_count), 32'(count_m));
        checkOutput("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic clearModel();
        ptr_m   = 0;
        count_m = '0;
        for (int i = 0; i < NREQ; i++) pending[i] = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_w    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_op_count", 32'(op_count), 32'd0);
        checkOutput("rst_fpu_a", 32'(fpu_a), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);

        $display("[TB] single op on requester 0");
        pending[0] = 1'b1; opa[0] = 16'h4400; opb[0] = 16'h4A20;
        runOp(0);
        checkOutput("sum_16_25", 32'(res_data), 32'h4C10);

        $display("[TB] cancellation on requester 1");
        pending[1] = 1'b1; opa[1] = 16'h4400; opb[1] = 16'hC400;
        runOp(1);
        checkOutput("sum_zero", 32'(res_data), 32'h0000);
        checkOutput("winner_req1", 32'(last_w), 32'd1);

        $display("[TB] reset while an operation is in ISSUE");
        pending[0] = 1'b1; opa[0] = rand_half(); opb[0] = rand_half();
        applyStimulus();
        @(posedge clk);
        #1;
        pending[0] = 1'b0;
        applyStimulus();
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_fpu_a", 32'(fpu_a), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_op_count", 32'(op_count), 32'd0);
        checkOutput("mid_rst_fpu_a", 32'(fpu_a), 32'd0);
        rst = 1'b0;
        clearModel();

        $display("[TB] contention with both requesters always valid");
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i]) begin
                    pending[i] = 1'b1;
                    opa[i]     = rand_half();
                    opb[i]     = rand_half();
                end
            end
            runOp(0);
            order[k] = last_w;
        end
        for (int k = 0; k < 4; k++) checkOutput("rr_order", 32'(order[k]), 32'(k % 2));

        $display("[TB] backpressure for five cycles");
        newRequests();
        runOp(5);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 30; t++) begin
            newRequests();
            runOp(int'($urandom_range(0, 3)));
        end

        $display("[TB] op_count wrap");
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        #1;
        count_m = 16'hFFFF;
        checkOutput("count_preload", 32'(op_count), 32'hFFFF);
        newRequests();
        runOp(0);
        checkOutput("count_wrap", 32'(op_count), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
